serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer built around a single shared full_adder cell. It accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake, then feeds them LSB-first through the one full_adder, one bit per clock. A carry flip-flop closes the loop. The block returns the WIDTH-bit sum and final carry over a second valid/ready handshake. This trades WIDTH cycles of latency for one adder cell's area, and is the sequencing layer above the combinational adder leaves.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.
CNT_W, $clog2(WIDTH+1), derived bit-counter width; not overridden by users.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start_valid  input  1  operands present on A_in/B_in/Cin_in.
start_ready  output  1  block can accept an operation.
A_in  input  WIDTH  operand A.
B_in  input  WIDTH  operand B.
Cin_in  input  1  carry-in for bit 0.
res_valid  output  1  Sum_out/Cout_out hold a completed result.
res_ready  input  1  consumer takes the result.
Sum_out  output  WIDTH  registered sum, A+B+Cin mod 2^WIDTH.
Cout_out  output  1  registered carry-out of the MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). Asserting it forces state IDLE and clears all registers at once, regardless of clk.
- Reset values: state=IDLE, start_ready=1, res_valid=0, busy=0, Sum_out=0, Cout_out=0, A/B/S shift regs=0, carry reg=0, count=0.
- FSM has three states:
  - IDLE: start_ready=1. On start_valid&&start_ready at an edge: A_sh<=A_in, B_sh<=B_in, carry<=Cin_in, count<=0, go to RUN. Otherwise stay.
  - RUN: start_ready=0. The full_adder inputs are A_sh[0], B_sh[0] and carry. Each edge:
    - S_sh<={fa_sum, S_sh[WIDTH-1:1]}
    - A_sh and B_sh shift right, zero-filled
    - carry<=fa_cout
    - count<=count+1
    - On the edge where count==WIDTH-1: Sum_out<={fa_sum, S_sh[WIDTH-1:1]}, Cout_out<=fa_cout, go to DONE.
  - DONE: res_valid=1, start_ready=0. On res_ready at an edge go to IDLE. Otherwise hold, with Sum_out/Cout_out stable.
- Latency: res_valid rises exactly WIDTH edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN edges, handoff).
- start_ready and res_valid are pure state decodes, with no combinational path from start_valid or res_ready.
- Sum_out/Cout_out update only on DONE entry. They keep the last result through IDLE and RUN.
- start_valid is ignored outside IDLE. Operand inputs are sampled only at the accepting edge and may change freely afterwards.
- No back-to-back overlap: start_ready is 0 in DONE, so the earliest new accept is the edge after the result handoff.
- WIDTH=1: RUN lasts one edge (count==0 is the terminal count).
- Reset mid-RUN or mid-DONE aborts the operation: no result is produced, and the outputs return to reset values.
- There are no arithmetic overflow flags. Overflow is reported only via Cout_out.

Decomposition:
- Package serial_add_pkg holds the state encoding localparams ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10, shared with the bench for state coverage.
- Sub-module: exactly one instance of the existing full_adder leaf. The carry register, shift registers and counter stay in serial_add_ctrl.

Test Plan:
1. WIDTH=8, A=8'h3C, B=8'h5A, Cin=0 -> res_valid exactly 8 edges after accept, Sum_out=8'h96, Cout_out=0.
2. A=8'hFF, B=8'h01, Cin=0 -> Sum_out=8'h00, Cout_out=1. Then A=8'hFF, B=8'hFF, Cin=1 -> Sum_out=8'hFF, Cout_out=1.
3. A=8'h00, B=8'h00, Cin=1 -> Sum_out=8'h01, Cout_out=0, confirming Cin enters at bit 0 only.
4. Backpressure: hold res_ready=0 for 5 cycles while driving start_valid=1 with new operands -> res_valid/Sum_out/Cout_out stable, start_ready=0, no second accept. Raise res_ready -> IDLE next edge, then the new op is accepted.
5. Pulse rst_n low for 1/3 cycle during RUN at count=4 -> immediate IDLE, all outputs at reset values. A following op 8'h12+8'h34 -> Sum_out=8'h46.
6. 1000 random operand/Cin vectors with random res_ready stalls, WIDTH=8 and WIDTH=1 builds -> every result equals (A+B+Cin) split into Sum/Cout, and latency equals WIDTH every time.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding used by the
// controller and by benches that want to observe state coverage.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder leaf.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: operands are shifted LSB-first through one full_adder, one bit per clock,
// with a carry flop closing the loop. Results are handed off over a valid/ready handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Cin_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] Sum_out,
  output logic             Cout_out,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] s_shift;

  full_adder u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_sum),
    .cout_o(fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_shift_w1
    assign s_shift = fa_sum;
  end else begin : g_shift_wn
    assign s_shift = {fa_sum, s_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = A_in;
          b_d     = B_in;
          carry_d = Cin_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        s_d     = s_shift;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = s_shift;
          cout_d  = fa_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_ready = (state_q == StIdle);
  assign res_valid   = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign Sum_out     = sum_q;
  assign Cout_out    = cout_q;

endmodule
